// File: rtl/layer_result_writer_pkg.sv
// Shared definitions for the layer result writer: FSM encoding and width helpers.
package layer_result_writer_pkg;

  // Controller states; encodings are fixed so other layers can decode them.
  typedef enum logic [1:0] {
    LRW_IDLE  = 2'd0,
    LRW_FILL  = 2'd1,
    LRW_FULL  = 2'd2,
    LRW_DRAIN = 2'd3
  } lrw_state_e;

  localparam int LRW_BIT_WIDTH_DEF  = 32;
  localparam int LRW_EXTRA_BITS_DEF = 2;
  localparam int LRW_DEPTH_DEF      = 2;

  // Stored word: flag bits sit above the IEEE-754 payload.
  function automatic int lrw_word_w(input int bit_width, input int extra_bits);
    return bit_width + extra_bits;
  endfunction

  // Memory address width; a single-entry memory still needs one address bit.
  function automatic int lrw_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold the value DEPTH itself.
  function automatic int lrw_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/layer_result_writer_if.sv
// Bus between a result producer/consumer and the layer result writer.
interface layer_result_writer_if
  import layer_result_writer_pkg::*;
#(
  parameter int BIT_WIDTH  = LRW_BIT_WIDTH_DEF,
  parameter int EXTRA_BITS = LRW_EXTRA_BITS_DEF,
  parameter int DEPTH      = LRW_DEPTH_DEF
) ();

  localparam int WORD_W = lrw_word_w(BIT_WIDTH, EXTRA_BITS);
  localparam int CNT_W  = lrw_count_w(DEPTH);

  logic              START;
  logic              IN_VALID;
  logic [WORD_W-1:0] IN_DATA;
  logic              DRAIN_REQ;
  logic [WORD_W-1:0] MEM_OUT;
  logic              OUT_VALID;
  logic [CNT_W-1:0]  COUNT;
  logic              FULL;
  logic              DONE;
  logic              OVERFLOW;

  // Producer / consumer side.
  modport master (
    output START, IN_VALID, IN_DATA, DRAIN_REQ,
    input  MEM_OUT, OUT_VALID, COUNT, FULL, DONE, OVERFLOW
  );

  // Writer side.
  modport slave (
    input  START, IN_VALID, IN_DATA, DRAIN_REQ,
    output MEM_OUT, OUT_VALID, COUNT, FULL, DONE, OVERFLOW
  );

endinterface

// File: rtl/layer_result_writer_result_ram.sv
// Result storage: DEPTH x word array, one synchronous write port, one registered read port.
module result_ram
  import layer_result_writer_pkg::*;
#(
  parameter int WORD_W = 34,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = lrw_addr_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_data;

  // Array write; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register; it holds its value when no read is issued, so the last streamed word persists.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/layer_result_writer.sv
// Capture buffer for accumulated layer results, drained back out one word per cycle.
module layer_result_writer
  import layer_result_writer_pkg::*;
#(
  parameter int BIT_WIDTH  = LRW_BIT_WIDTH_DEF,
  parameter int EXTRA_BITS = LRW_EXTRA_BITS_DEF,
  parameter int DEPTH      = LRW_DEPTH_DEF
) (
  input logic                  CLK,
  input logic                  RESET,
  layer_result_writer_if.slave bus
);

  localparam int WORD_W = lrw_word_w(BIT_WIDTH, EXTRA_BITS);
  localparam int ADDR_W = lrw_addr_w(DEPTH);
  localparam int CNT_W  = lrw_count_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  lrw_state_e       r_state;
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_full;
  logic             r_done;
  logic             r_overflow;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_last_write;
  logic [WORD_W-1:0] w_rd_data;

  // Memory port control; reset suppresses any write or read on the aborting edge.
  always_comb begin
    w_wr_en      = RESET && (r_state == LRW_FILL) && bus.IN_VALID;
    w_wr_addr    = r_wr_ptr[ADDR_W-1:0];
    w_last_write = w_wr_en && (r_wr_ptr == (DEPTH_C - ONE_C));
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    if (RESET) begin
      if ((r_state == LRW_FULL) && bus.DRAIN_REQ) begin
        w_rd_en   = 1'b1;
        w_rd_addr = '0;
      end else if ((r_state == LRW_DRAIN) && (r_rd_ptr != DEPTH_C)) begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_rd_ptr[ADDR_W-1:0];
      end
    end
  end

  result_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_result_ram (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.IN_DATA),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Controller FSM: pointers, count and all status flags registered here.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= LRW_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LRW_IDLE: begin
          // START wins over a coincident IN_VALID: arm only, no write, no overflow.
          if (bus.START) begin
            r_state  <= LRW_FILL;
            r_wr_ptr <= '0;
            r_count  <= '0;
          end else if (bus.IN_VALID) begin
            r_overflow <= 1'b1;
          end
        end
        LRW_FILL: begin
          if (bus.IN_VALID) begin
            r_wr_ptr <= r_wr_ptr + ONE_C;
            r_count  <= r_count + ONE_C;
            if (w_last_write) begin
              r_state <= LRW_FULL;
              r_full  <= 1'b1;
            end
          end
        end
        LRW_FULL: begin
          if (bus.IN_VALID) begin
            r_overflow <= 1'b1;
          end
          // Entry 0 is read on this same edge, so the first word appears one edge after the request.
          if (bus.DRAIN_REQ) begin
            r_state     <= LRW_DRAIN;
            r_full      <= 1'b0;
            r_out_valid <= 1'b1;
            r_rd_ptr    <= ONE_C;
          end
        end
        LRW_DRAIN: begin
          if (bus.IN_VALID) begin
            r_overflow <= 1'b1;
          end
          if (r_rd_ptr == DEPTH_C) begin
            r_state     <= LRW_IDLE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_count     <= '0;
          end else begin
            r_rd_ptr <= r_rd_ptr + ONE_C;
          end
        end
        default: begin
          r_state <= LRW_IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_OUT   = w_rd_data;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.COUNT     = r_count;
  assign bus.FULL      = r_full;
  assign bus.DONE      = r_done;
  assign bus.OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_layer_result_writer.sv
// Bench for layer_result_writer: DEPTH=2 and DEPTH=1 builds, scoreboard on streamed words.
module tb_layer_result_writer;

  localparam logic [33:0] W1    = 34'h0_3F9D70A4;
  localparam logic [33:0] W2    = 34'h0_3E4CCCCD;
  localparam logic [33:0] W3    = 34'h2_C0490FDB;
  localparam logic [33:0] W4    = 34'h1_7F800000;
  localparam logic [33:0] W5    = 34'h3_12345678;
  localparam logic [33:0] W6    = 34'h0_87654321;
  localparam logic [33:0] W7    = 34'h3_3F800000;
  localparam logic [33:0] JUNK1 = 34'h3_DEADBEEF;
  localparam logic [33:0] JUNK2 = 34'h3_FFFFFFFF;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_fail;
  int valid_a;
  int valid_b;
  int done_a;
  int done_b;
  logic [33:0] q_a[$];
  logic [33:0] q_b[$];

  layer_result_writer_if #(.BIT_WIDTH(32), .EXTRA_BITS(2), .DEPTH(2)) bus_a ();
  layer_result_writer_if #(.BIT_WIDTH(32), .EXTRA_BITS(2), .DEPTH(1)) bus_b ();

  layer_result_writer #(.BIT_WIDTH(32), .EXTRA_BITS(2), .DEPTH(2)) dut_a (
    .CLK   (clk),
    .RESET (rst_a),
    .bus   (bus_a.slave)
  );

  layer_result_writer #(.BIT_WIDTH(32), .EXTRA_BITS(2), .DEPTH(1)) dut_b (
    .CLK   (clk),
    .RESET (rst_b),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor, DEPTH=2 instance.
  always @(negedge clk) begin
    if (bus_a.OUT_VALID === 1'b1) begin
      valid_a++;
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_stream: got unexpected word %h, expected none", bus_a.MEM_OUT);
      end else begin
        logic [33:0] e;
        e = q_a.pop_front();
        $display("a out %h (exp %h)", bus_a.MEM_OUT, e);
        if (bus_a.MEM_OUT !== e) begin
          n_fail++;
          $display("FAIL a_stream: got %h, expected %h", bus_a.MEM_OUT, e);
        end
      end
    end
    if (bus_a.DONE === 1'b1) done_a++;
  end

  // Scoreboard monitor, DEPTH=1 instance.
  always @(negedge clk) begin
    if (bus_b.OUT_VALID === 1'b1) begin
      valid_b++;
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_stream: got unexpected word %h, expected none", bus_b.MEM_OUT);
      end else begin
        logic [33:0] e;
        e = q_b.pop_front();
        $display("b out %h (exp %h)", bus_b.MEM_OUT, e);
        if (bus_b.MEM_OUT !== e) begin
          n_fail++;
          $display("FAIL b_stream: got %h, expected %h", bus_b.MEM_OUT, e);
        end
      end
    end
    if (bus_b.DONE === 1'b1) done_b++;
  end

  initial begin
    n_checks = 0; n_fail = 0;
    valid_a = 0; valid_b = 0; done_a = 0; done_b = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.START = 0; bus_a.IN_VALID = 0; bus_a.IN_DATA = '0; bus_a.DRAIN_REQ = 0;
    bus_b.START = 0; bus_b.IN_VALID = 0; bus_b.IN_DATA = '0; bus_b.DRAIN_REQ = 0;
    tick(); tick();

    // Reset state
    chk("a_rst_count", bus_a.COUNT, 0);
    chk("a_rst_full", bus_a.FULL, 0);
    chk("a_rst_valid", bus_a.OUT_VALID, 0);
    chk("a_rst_done", bus_a.DONE, 0);
    chk("a_rst_ovf", bus_a.OVERFLOW, 0);
    chk("a_rst_memout", bus_a.MEM_OUT, 0);
    rst_a = 1'b1;

    // START with IN_VALID in IDLE: arms only
    bus_a.START = 1; bus_a.IN_VALID = 1; bus_a.IN_DATA = JUNK1;
    tick();
    chk("a_arm_count", bus_a.COUNT, 0);
    chk("a_arm_ovf", bus_a.OVERFLOW, 0);
    $display("a arm");

    // First write
    bus_a.START = 0; bus_a.IN_VALID = 1; bus_a.IN_DATA = W1;
    tick();
    chk("a_wr1_count", bus_a.COUNT, 1);
    chk("a_wr1_full", bus_a.FULL, 0);
    $display("a write %h", W1);

    // Gap cycle with START and DRAIN_REQ, both ignored in FILL
    bus_a.IN_VALID = 0; bus_a.START = 1; bus_a.DRAIN_REQ = 1;
    tick();
    chk("a_gap_count", bus_a.COUNT, 1);
    chk("a_gap_full", bus_a.FULL, 0);

    // Final write with coincident DRAIN_REQ (ignored)
    bus_a.START = 0; bus_a.IN_VALID = 1; bus_a.IN_DATA = W2; bus_a.DRAIN_REQ = 1;
    tick();
    chk("a_wr2_count", bus_a.COUNT, 2);
    chk("a_wr2_full", bus_a.FULL, 1);
    $display("a write %h", W2);

    bus_a.IN_VALID = 0; bus_a.DRAIN_REQ = 0;
    tick();
    chk("a_hold_full", bus_a.FULL, 1);
    chk("a_hold_valid", bus_a.OUT_VALID, 0);

    // Overflow in FULL
    bus_a.IN_VALID = 1; bus_a.IN_DATA = JUNK2;
    tick();
    chk("a_ovf_set", bus_a.OVERFLOW, 1);
    chk("a_ovf_full", bus_a.FULL, 1);
    chk("a_ovf_count", bus_a.COUNT, 2);
    bus_a.IN_VALID = 0;

    // Drain; DRAIN_REQ and START repeated during DRAIN are ignored
    q_a.push_back(W1); q_a.push_back(W2);
    bus_a.DRAIN_REQ = 1;
    tick();  // t0
    chk("a_t0_valid", bus_a.OUT_VALID, 1);
    chk("a_t0_full", bus_a.FULL, 0);
    bus_a.START = 1;
    tick();  // t0+1
    chk("a_t1_valid", bus_a.OUT_VALID, 1);
    chk("a_t1_done", bus_a.DONE, 0);
    bus_a.START = 0; bus_a.DRAIN_REQ = 0;
    tick();  // t0+2
    chk("a_t2_valid", bus_a.OUT_VALID, 0);
    chk("a_t2_done", bus_a.DONE, 1);
    chk("a_t2_count", bus_a.COUNT, 0);
    chk("a_t2_memout_hold", bus_a.MEM_OUT, W2);
    tick();
    chk("a_t3_done", bus_a.DONE, 0);
    chk("a_ovf_sticky", bus_a.OVERFLOW, 1);

    // Second cycle with nonzero flag bits
    bus_a.START = 1;
    tick();
    bus_a.START = 0; bus_a.IN_VALID = 1; bus_a.IN_DATA = W3;
    tick();
    bus_a.IN_DATA = W4;
    tick();
    bus_a.IN_VALID = 0;
    chk("a_c2_full", bus_a.FULL, 1);
    q_a.push_back(W3); q_a.push_back(W4);
    bus_a.DRAIN_REQ = 1;
    tick();
    bus_a.DRAIN_REQ = 0;
    tick();
    tick();
    chk("a_c2_done", bus_a.DONE, 1);
    tick();

    // Third cycle, reset applied at t0+1
    bus_a.START = 1;
    tick();
    bus_a.START = 0; bus_a.IN_VALID = 1; bus_a.IN_DATA = W5;
    tick();
    bus_a.IN_DATA = W6;
    tick();
    bus_a.IN_VALID = 0;
    q_a.push_back(W5);
    bus_a.DRAIN_REQ = 1;
    tick();  // t0
    chk("a_r_t0_valid", bus_a.OUT_VALID, 1);
    bus_a.DRAIN_REQ = 0;
    rst_a = 1'b0;
    tick();  // t0+1 with reset
    chk("a_r_valid", bus_a.OUT_VALID, 0);
    chk("a_r_memout", bus_a.MEM_OUT, 0);
    chk("a_r_ovf", bus_a.OVERFLOW, 0);
    chk("a_r_count", bus_a.COUNT, 0);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_r_no_done", bus_a.DONE, 0);
      chk("a_r_no_valid", bus_a.OUT_VALID, 0);
    end

    // IN_VALID alone in IDLE sets OVERFLOW
    bus_a.IN_VALID = 1; bus_a.IN_DATA = JUNK1;
    tick();
    bus_a.IN_VALID = 0;
    chk("a_idle_ovf", bus_a.OVERFLOW, 1);

    // DEPTH=1 build
    chk("b_rst_memout", bus_b.MEM_OUT, 0);
    chk("b_rst_full", bus_b.FULL, 0);
    rst_b = 1'b1;
    bus_b.START = 1;
    tick();
    bus_b.START = 0; bus_b.IN_VALID = 1; bus_b.IN_DATA = W7;
    tick();
    bus_b.IN_VALID = 0;
    chk("b_full", bus_b.FULL, 1);
    chk("b_count", bus_b.COUNT, 1);
    $display("b write %h", W7);
    q_b.push_back(W7);
    bus_b.DRAIN_REQ = 1;
    tick();  // t0
    bus_b.DRAIN_REQ = 0;
    chk("b_t0_valid", bus_b.OUT_VALID, 1);
    chk("b_t0_done", bus_b.DONE, 0);
    tick();  // t0+1
    chk("b_t1_valid", bus_b.OUT_VALID, 0);
    chk("b_t1_done", bus_b.DONE, 1);
    chk("b_t1_count", bus_b.COUNT, 0);
    tick();
    chk("b_t2_done", bus_b.DONE, 0);

    tick(); tick();
    chk("a_queue_left", q_a.size(), 0);
    chk("b_queue_left", q_b.size(), 0);
    chk("a_valid_cycles", valid_a, 5);
    chk("b_valid_cycles", valid_b, 1);
    chk("a_done_pulses", done_a, 2);
    chk("b_done_pulses", done_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_result_writer.md
# layer_result_writer

Capture buffer on the output side of `LINEAR_LAYER`, the write-side counterpart of `WEIGHTS_ROM`. It accepts accumulated results (`ACC_RESULT`, extended-float format: `EXTRA_BITS` flag bits above a 32-bit IEEE-754 word) into an internal memory of `DEPTH` entries. On request, it streams them back out one per cycle, with the same port shape as `WEIGHTS_ROM`, so the next layer can consume them as `INPUT_SCALER`.

## Interface
Parameters:
- `BIT_WIDTH`, 32: float payload width.
- `EXTRA_BITS`, 2: flag bits prepended to the payload; stored verbatim.
- `DEPTH`, 2: number of entries, equal to the producing layer's `NUM_UNKNOWNS`; legal range is 1 and up.

Ports. One clock; `RESET` is synchronous and active-low.
- `CLK` in 1: clock; all state changes on the rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `START` in 1: pulse that arms a fill; honoured only in IDLE.
- `IN_VALID` in 1: `IN_DATA` is valid this cycle.
- `IN_DATA` in `BIT_WIDTH+EXTRA_BITS`: result word from `ACC_RESULT`.
- `DRAIN_REQ` in 1: request to stream the stored entries; honoured only in FULL.
- `MEM_OUT` out `BIT_WIDTH+EXTRA_BITS`: streamed entry, registered.
- `OUT_VALID` out 1: `MEM_OUT` holds a valid entry.
- `COUNT` out `$clog2(DEPTH+1)`: number of entries written in the current fill.
- `FULL` out 1: high while in FULL.
- `DONE` out 1: one-cycle pulse after the last entry is streamed.
- `OVERFLOW` out 1: sticky flag; set by `IN_VALID` outside FILL; cleared only by reset.

## Operation
- **States:** IDLE, FILL, FULL, DRAIN.
- **Reset** (RESET=0 at an edge): state IDLE; `wr_ptr`, `rd_ptr`, `COUNT` = 0; `MEM_OUT` = 0; `OUT_VALID`, `FULL`, `DONE`, `OVERFLOW` = 0. Memory contents are not cleared. Reset mid-fill or mid-drain aborts immediately with no further writes or outputs.
- **IDLE:**
  - `START`=1 → FILL, `wr_ptr` and `COUNT` cleared.
  - `IN_VALID`=1 without `START` → sets `OVERFLOW`; the data is dropped.
- **FILL:**
  - On each `IN_VALID`=1: mem[`wr_ptr`] ← `IN_DATA`, and `wr_ptr`, `COUNT` increment.
  - The write that makes `COUNT`=`DEPTH` moves the block to FULL on the same edge.
  - `START` is ignored.
- **FULL:**
  - `FULL`=1.
  - `IN_VALID` sets `OVERFLOW`; memory is unchanged.
  - `DRAIN_REQ`=1 → DRAIN.
- **DRAIN:**
  - Entries are emitted in index order 0..`DEPTH`-1, one per cycle, with no stalls.
  - `IN_VALID` sets `OVERFLOW`.
  - `DRAIN_REQ` and `START` are ignored.
  - After the last entry: state IDLE, `DONE` pulses, `COUNT` is cleared.
- **Data:** words are stored and returned bit-exact; the block does no arithmetic or format conversion.
- **Simultaneous events:**
  - `START` with `IN_VALID` in IDLE: arms only. The word is not written and `OVERFLOW` is not set.
  - `DRAIN_REQ` in the same cycle as the final FILL write: ignored; a new request is needed in FULL.

## Timing
- **Write:** the word is stored on the edge that samples `IN_VALID`=1. `COUNT` updates on that edge.
- **FULL assertion:** `FULL` is registered high after the edge of the `DEPTH`-th write.
- **Drain start:** on the edge t0 that samples `DRAIN_REQ` in FULL:
  - `MEM_OUT` ← mem[0], `OUT_VALID` ← 1, `rd_ptr` ← 1, `FULL` ← 0.
  - Latency is 1 edge, matching `WEIGHTS_ROM`.
- **Drain stream:** at edge t0+k, for k < `DEPTH`, `MEM_OUT` ← mem[k].
- **Drain end:** at edge t0+`DEPTH`:
  - `OUT_VALID` ← 0, `DONE` ← 1, state IDLE.
  - `MEM_OUT` holds its last value.
  - `DONE` returns to 0 at t0+`DEPTH`+1.
- **Throughput:** one write per cycle in FILL. A complete cycle takes `DEPTH` + `DEPTH` + 2 edges minimum (START, fill, request, drain).
- **`DEPTH`=1:** one write reaches FULL; the drain is a single `OUT_VALID` cycle, followed by `DONE`.

## Structure
- **Shared `definitions.v` additions:**
  - state encodings `LRW_IDLE`=0, `LRW_FILL`=1, `LRW_FULL`=2, `LRW_DRAIN`=3;
  - a word-width macro (`BIT_WIDTH+EXTRA_BITS`) shared with `LINEAR_LAYER` and `WEIGHTS_ROM`.
- **Sub-module `result_ram`:**
  - `DEPTH` × word register array;
  - one synchronous write port and one registered read port;
  - no reset on the array.
- **Top module:** FSM, pointers, flags.

## Test plan
- **Fill and drain, `DEPTH`=2:**
  - Stimulus: reset, `START`, then writes 34'h0_3F9D70A4 (1.23) and 34'h0_3E4CCCCD (0.2), then `DRAIN_REQ`.
  - Response: `MEM_OUT` shows 3F9D70A4 then 3E4CCCCD with flags 2'b00 on consecutive cycles, `OUT_VALID` high for exactly 2 cycles, `DONE` pulses once.
- **Gapped writes:**
  - Stimulus: `IN_VALID` alternating 1/0.
  - Response: `COUNT` steps 0→1→1→2; `FULL` rises only after the 2nd write.
- **Overflow:**
  - Stimulus: a third `IN_VALID` while in FULL.
  - Response: `OVERFLOW`=1 and stays set; drained data still equals the first two words.
- **Ignored inputs:**
  - `START` during FILL causes no pointer reset.
  - `DRAIN_REQ` during FILL and during DRAIN has no effect.
  - `IN_VALID` with `START` in IDLE writes nothing.
- **Reset mid-drain:**
  - Stimulus: `RESET`=0 at t0+1.
  - Response: next edge gives `OUT_VALID`=0, state IDLE, `DONE` never pulses.
- **`DEPTH`=1 build:**
  - Stimulus: a single write, then a drain.
  - Response: 1-cycle `OUT_VALID`, `DONE` at t0+1.
